// File: rtl/cci_mpf_rd_arbiter_if.sv
// Read-arbiter boundary: AFU client request/response lanes plus the MPF c0 read channel.
// slave = arbiter view, master = surrounding logic (clients + MPF stack).
interface cci_mpf_rd_arbiter_if #(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = 42,
  parameter int MDATA_W   = 12
);
  localparam int ID_W  = $clog2(N_CLIENTS);
  localparam int TAG_W = MDATA_W + ID_W;

  logic [N_CLIENTS-1:0]         cl_req_valid;
  logic [N_CLIENTS*ADDR_W-1:0]  cl_req_addr;
  logic [N_CLIENTS*MDATA_W-1:0] cl_req_mdata;
  logic [N_CLIENTS-1:0]         cl_req_ack;
  logic [N_CLIENTS-1:0]         cl_rsp_valid;
  logic [MDATA_W-1:0]           cl_rsp_mdata;
  logic [511:0]                 cl_rsp_data;

  logic                         c0_req_valid;
  logic [ADDR_W-1:0]            c0_req_addr;
  logic [TAG_W-1:0]             c0_req_mdata;
  logic                         c0_almost_full;
  logic                         c0_rsp_valid;
  logic [TAG_W-1:0]             c0_rsp_mdata;
  logic [511:0]                 c0_rsp_data;

  logic                         err_bad_rsp;

  modport slave (
    input  cl_req_valid, cl_req_addr, cl_req_mdata,
    input  c0_almost_full, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    output cl_req_ack, cl_rsp_valid, cl_rsp_mdata, cl_rsp_data,
    output c0_req_valid, c0_req_addr, c0_req_mdata, err_bad_rsp
  );

  modport master (
    output cl_req_valid, cl_req_addr, cl_req_mdata,
    output c0_almost_full, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    input  cl_req_ack, cl_rsp_valid, cl_rsp_mdata, cl_rsp_data,
    input  c0_req_valid, c0_req_addr, c0_req_mdata, err_bad_rsp
  );
endinterface

// File: rtl/cci_mpf_rd_arbiter.sv
// Round-robin share of the MPF c0 read channel: tags Mdata with client ID, caps in-flight reads per
// client, routes responses back by tag (1-cycle each way). Optional counters: CCI_MPF_RD_ARB_STATS_EN.
module cci_mpf_rd_arbiter #(
  parameter int N_CLIENTS       = 4,
  parameter int ADDR_W          = 42,
  parameter int MDATA_W         = 12,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  cci_mpf_rd_arbiter_if.slave        bus
`ifdef CCI_MPF_RD_ARB_STATS_EN
  ,
  output logic [N_CLIENTS*32-1:0]    stat_grants,
  output logic [31:0]                stat_blocked
`endif
);
  localparam int ID_W  = $clog2(N_CLIENTS);
  localparam int TAG_W = MDATA_W + ID_W;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N_CLIENTS-1:0] eligible;
  logic                 grant_vld;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     cnt_q [N_CLIENTS];
  logic [CNT_W-1:0]     cnt_d [N_CLIENTS];

  logic                 c0_req_vld_q;
  logic [ADDR_W-1:0]    c0_req_addr_q;
  logic [TAG_W-1:0]     c0_req_mdata_q;

  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_owner_busy;
  logic                 rsp_ok;
  logic [N_CLIENTS-1:0] cl_rsp_vld_q;
  logic [MDATA_W-1:0]   cl_rsp_mdata_q;
  logic [511:0]         cl_rsp_data_q;
  logic                 err_q, err_d;

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      eligible[i] = bus.cl_req_valid[i] && (cnt_q[i] < CNT_MAX);
    end
  end

  // Search starts one past the previous winner; idx carries an extra bit so the wrap is a subtract.
  always_comb begin
    logic [ID_W:0] idx;
    logic          found;
    found  = 1'b0;
    idx    = '0;
    win_id = last_grant_q;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      idx = {1'b0, last_grant_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_CLIENTS)) begin
        idx = idx - (ID_W+1)'(N_CLIENTS);
      end
      if (!found && eligible[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = idx[ID_W-1:0];
      end
    end
    grant_vld = found && !bus.c0_almost_full && !reset;
  end

  assign last_grant_d   = grant_vld ? win_id : last_grant_q;
  assign bus.cl_req_ack = grant_vld ? (N_CLIENTS'(1) << win_id) : '0;

  // Only tags that decode to a real client with reads in flight are routed.
  assign rsp_id = bus.c0_rsp_mdata[TAG_W-1 -: ID_W];

  always_comb begin
    rsp_owner_busy = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (rsp_id == ID_W'(i)) begin
        rsp_owner_busy = (cnt_q[i] != '0);
      end
    end
  end

  assign rsp_ok = bus.c0_rsp_valid && rsp_owner_busy;
  assign err_d  = err_q || (bus.c0_rsp_valid && !rsp_owner_busy);

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      logic inc, dec;
      inc      = grant_vld && (win_id == ID_W'(i));
      dec      = rsp_ok && (rsp_id == ID_W'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q   <= ID_W'(N_CLIENTS - 1);
      for (int i = 0; i < N_CLIENTS; i++) begin
        cnt_q[i] <= '0;
      end
      c0_req_vld_q   <= 1'b0;
      c0_req_addr_q  <= '0;
      c0_req_mdata_q <= '0;
      cl_rsp_vld_q   <= '0;
      cl_rsp_mdata_q <= '0;
      cl_rsp_data_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      for (int i = 0; i < N_CLIENTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      c0_req_vld_q <= grant_vld;
      if (grant_vld) begin
        c0_req_addr_q  <= bus.cl_req_addr[int'(win_id)*ADDR_W +: ADDR_W];
        c0_req_mdata_q <= {win_id, bus.cl_req_mdata[int'(win_id)*MDATA_W +: MDATA_W]};
      end
      cl_rsp_vld_q <= rsp_ok ? (N_CLIENTS'(1) << rsp_id) : '0;
      if (rsp_ok) begin
        cl_rsp_mdata_q <= bus.c0_rsp_mdata[MDATA_W-1:0];
        cl_rsp_data_q  <= bus.c0_rsp_data;
      end
      err_q <= err_d;
    end
  end

  assign bus.c0_req_valid = c0_req_vld_q;
  assign bus.c0_req_addr  = c0_req_addr_q;
  assign bus.c0_req_mdata = c0_req_mdata_q;
  assign bus.cl_rsp_valid = cl_rsp_vld_q;
  assign bus.cl_rsp_mdata = cl_rsp_mdata_q;
  assign bus.cl_rsp_data  = cl_rsp_data_q;
  assign bus.err_bad_rsp  = err_q;

`ifdef CCI_MPF_RD_ARB_STATS_EN
  logic [31:0] stat_grants_q [N_CLIENTS];
  logic [31:0] stat_blocked_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        stat_grants_q[i] <= '0;
      end
      stat_blocked_q <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (grant_vld && (win_id == ID_W'(i))) begin
          stat_grants_q[i] <= stat_grants_q[i] + 32'd1;
        end
      end
      if ((|bus.cl_req_valid) && !grant_vld) begin
        stat_blocked_q <= stat_blocked_q + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      stat_grants[i*32 +: 32] = stat_grants_q[i];
    end
  end

  assign stat_blocked = stat_blocked_q;
`endif
endmodule

// File: tb/tb_cci_mpf_rd_arbiter.sv
// Bench for cci_mpf_rd_arbiter: ack vectors, request/response scoreboards, reset and bad-tag cases.
module tb_cci_mpf_rd_arbiter;
  localparam int N    = 4;
  localparam int AW   = 42;
  localparam int MW   = 12;
  localparam int MAXO = 3;
  localparam int TW   = MW + 2;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cci_mpf_rd_arbiter_if #(.N_CLIENTS(N), .ADDR_W(AW), .MDATA_W(MW)) bus ();
  cci_mpf_rd_arbiter_if #(.N_CLIENTS(3), .ADDR_W(AW), .MDATA_W(MW)) bus3 ();

`ifdef CCI_MPF_RD_ARB_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_blocked;
  logic [3*32-1:0] stat_grants3;
  logic [31:0]     stat_blocked3;
`endif

  cci_mpf_rd_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .MDATA_W(MW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef CCI_MPF_RD_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_blocked(stat_blocked)
`endif
  );

  cci_mpf_rd_arbiter #(.N_CLIENTS(3), .ADDR_W(AW), .MDATA_W(MW), .MAX_OUTSTANDING(2)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
`ifdef CCI_MPF_RD_ARB_STATS_EN
    , .stat_grants(stat_grants3), .stat_blocked(stat_blocked3)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct { logic [AW-1:0] addr; logic [TW-1:0] md; } req_exp_t;
  typedef struct { logic [N-1:0] vld; logic [MW-1:0] md; logic [511:0] data; } rsp_exp_t;
  typedef struct { logic [N-1:0] vld; logic af; logic [N-1:0] ack; } vec_t;

  req_exp_t      req_q[$];
  rsp_exp_t      rsp_q[$];
  int            mcnt[N];
  logic          err_exp;
  logic [AW-1:0] caddr[N];
  logic [MW-1:0] cmd[N];
  vec_t          vecs[17];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic refresh(input int i);
    caddr[i] = {10'(i), 32'($urandom)};
    cmd[i]   = 12'($urandom);
  endtask

  task automatic model_clear();
    req_q.delete();
    rsp_q.delete();
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    err_exp = 1'b0;
  endtask

  task automatic check_outputs();
    req_exp_t r;
    rsp_exp_t s;
    if (req_q.size() > 0) begin
      r = req_q.pop_front();
      chk("c0_req_valid", {511'b0, bus.c0_req_valid}, 512'd1);
      chk("c0_req_addr", bus.c0_req_addr, r.addr);
      chk("c0_req_mdata", bus.c0_req_mdata, r.md);
    end else begin
      chk("c0_req_valid_idle", {511'b0, bus.c0_req_valid}, 512'd0);
    end
    if (rsp_q.size() > 0) begin
      s = rsp_q.pop_front();
      chk("cl_rsp_valid", bus.cl_rsp_valid, s.vld);
      chk("cl_rsp_mdata", bus.cl_rsp_mdata, s.md);
      chk("cl_rsp_data", bus.cl_rsp_data, s.data);
    end else begin
      chk("cl_rsp_valid_idle", bus.cl_rsp_valid, '0);
    end
    chk("err_bad_rsp", {511'b0, bus.err_bad_rsp}, {511'b0, err_exp});
  endtask

  // One clock: check last edge's registered outputs, drive new inputs, check the combinational ack.
  task automatic run_cycle(input logic [N-1:0] vld, input logic af, input logic rv,
                           input logic [1:0] rtag, input logic [MW-1:0] rmd,
                           input logic [N-1:0] exp_ack);
    logic [511:0] d;
    logic         good;
    rsp_exp_t     s;
    req_exp_t     r;
    @(negedge clk);
    check_outputs();
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    for (int i = 0; i < N; i++) begin
      bus.cl_req_addr[i*AW +: AW]  = caddr[i];
      bus.cl_req_mdata[i*MW +: MW] = cmd[i];
    end
    bus.cl_req_valid   = vld;
    bus.c0_almost_full = af;
    bus.c0_rsp_valid   = rv;
    bus.c0_rsp_mdata   = {rtag, rmd};
    bus.c0_rsp_data    = d;
    #1;
    chk("cl_req_ack", bus.cl_req_ack, exp_ack);
    good = rv && (mcnt[rtag] > 0);
    if (rv && !good) err_exp = 1'b1;
    if (good) begin
      s.vld  = N'(1) << rtag;
      s.md   = rmd;
      s.data = d;
      rsp_q.push_back(s);
      mcnt[rtag]--;
    end
    for (int i = 0; i < N; i++) begin
      if (exp_ack[i]) begin
        r.addr = caddr[i];
        r.md   = {2'(i), cmd[i]};
        req_q.push_back(r);
        mcnt[i]++;
        refresh(i);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.cl_req_valid    = '1;
    bus.c0_almost_full  = 1'b0;
    bus.c0_rsp_valid    = 1'b0;
    bus3.cl_req_valid   = '0;
    bus3.c0_rsp_valid   = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_ack", bus.cl_req_ack, '0);
    chk("rst_c0_req_valid", {511'b0, bus.c0_req_valid}, 512'd0);
    chk("rst_c0_req_addr", bus.c0_req_addr, '0);
    chk("rst_c0_req_mdata", bus.c0_req_mdata, '0);
    chk("rst_cl_rsp_valid", bus.cl_rsp_valid, '0);
    chk("rst_err", {511'b0, bus.err_bad_rsp}, 512'd0);
    chk("rst_err_n3", {511'b0, bus3.err_bad_rsp}, 512'd0);
    repeat (2) @(negedge clk);
    bus.cl_req_valid = '0;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b0;
    bus.cl_req_valid = '0;  bus.cl_req_addr = '0;  bus.cl_req_mdata = '0;
    bus.c0_almost_full = 1'b0; bus.c0_rsp_valid = 1'b0;
    bus.c0_rsp_mdata = '0;  bus.c0_rsp_data = '0;
    bus3.cl_req_valid = '0; bus3.cl_req_addr = '0; bus3.cl_req_mdata = '0;
    bus3.c0_almost_full = 1'b0; bus3.c0_rsp_valid = 1'b0;
    bus3.c0_rsp_mdata = '0; bus3.c0_rsp_data = '0;
    for (int i = 0; i < N; i++) refresh(i);
    model_clear();

    // Rotation across all four, then a stall window with clients 0 and 3, then the cap bites.
    for (int v = 0; v < 8; v++) vecs[v] = '{4'hF, 1'b0, 4'(1 << (v % 4))};
    for (int v = 8; v < 13; v++) vecs[v] = '{4'b1001, 1'b1, 4'b0000};
    vecs[13] = '{4'b1001, 1'b0, 4'b0001};
    vecs[14] = '{4'b1001, 1'b0, 4'b1000};
    vecs[15] = '{4'b1001, 1'b0, 4'b0000};
    vecs[16] = '{4'b0000, 1'b0, 4'b0000};

    do_reset();
    for (int v = 0; v < 17; v++) run_cycle(vecs[v].vld, vecs[v].af, 1'b0, 2'd0, 12'h0, vecs[v].ack);

    // Single client, fixed address/Mdata, tag prepended.
    do_reset();
    caddr[2] = 42'h123;
    cmd[2]   = 12'h5A5;
    run_cycle(4'b0100, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0100);
    run_cycle(4'b0000, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0000);
    chk("t2_addr", bus.c0_req_addr, 42'h123);
    chk("t2_mdata", bus.c0_req_mdata, 14'h25A5);

    // Outstanding cap on client 1, released by one response.
    do_reset();
    repeat (3) run_cycle(4'b0010, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0010);
    repeat (2) run_cycle(4'b0010, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0000);
    run_cycle(4'b0010, 1'b0, 1'b1, 2'd1, 12'h3C3, 4'b0000);
    run_cycle(4'b0010, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0010);
    chk("t3_rsp_valid", bus.cl_rsp_valid, 4'b0010);
    run_cycle(4'b0010, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0000);
    run_cycle(4'b0000, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0000);

    // Bad tags: out of range on a 3-client arbiter, idle owner on the 4-client one.
    do_reset();
    @(negedge clk);
    bus3.c0_rsp_valid = 1'b1;
    bus3.c0_rsp_mdata = {2'd3, 12'h0AB};
    @(negedge clk);
    bus3.c0_rsp_valid = 1'b0;
    chk("n3_rsp_valid", bus3.cl_rsp_valid, 3'b000);
    chk("n3_err", {511'b0, bus3.err_bad_rsp}, 512'd1);
    repeat (3) @(negedge clk);
    chk("n3_err_sticky", {511'b0, bus3.err_bad_rsp}, 512'd1);
    run_cycle(4'b0000, 1'b0, 1'b1, 2'd3, 12'h111, 4'b0000);
    run_cycle(4'b1000, 1'b0, 1'b0, 2'd0, 12'h0, 4'b1000);
    chk("t5_err", {511'b0, bus.err_bad_rsp}, 512'd1);
    run_cycle(4'b0000, 1'b0, 1'b1, 2'd3, 12'h222, 4'b0000);
    repeat (2) run_cycle(4'b0000, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0000);

    // Same-cycle grant and response on client 0 leaves the count at 1: exactly two more grants fit.
    do_reset();
    run_cycle(4'b0001, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0001);
    run_cycle(4'b0001, 1'b0, 1'b1, 2'd0, 12'h777, 4'b0001);
    run_cycle(4'b0001, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0001);
    run_cycle(4'b0001, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0001);
    run_cycle(4'b0001, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0000);
    run_cycle(4'b1111, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0010);
    run_cycle(4'b1111, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0100);

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    check_outputs();
    bus.cl_req_valid = '1;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ack", bus.cl_req_ack, '0);
    chk("mid_rst_c0_valid", {511'b0, bus.c0_req_valid}, 512'd0);
    chk("mid_rst_c0_addr", bus.c0_req_addr, '0);
    chk("mid_rst_rsp_valid", bus.cl_rsp_valid, '0);
    model_clear();
    @(negedge clk);
    bus.cl_req_valid = '0;
    reset = 1'b0;
    run_cycle(4'b1111, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0001);
    run_cycle(4'b0000, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0000);
    run_cycle(4'b0000, 1'b0, 1'b0, 2'd0, 12'h0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
